// File: rtl/div_clk_monitor_if.sv
// Status and stimulus bundle between the divided-clock monitor and its user.
interface div_clk_monitor_if;
    logic       i_en;
    logic       i_div_clk;
    logic       o_rise_pulse;
    logic       o_fall_pulse;
    logic       o_locked;
    logic       o_err;
    logic       o_lost;
    logic [7:0] o_last_half;

    // Side that drives the enable and the clock under test.
    modport master (
        output i_en,
        output i_div_clk,
        input  o_rise_pulse,
        input  o_fall_pulse,
        input  o_locked,
        input  o_err,
        input  o_lost,
        input  o_last_half
    );

    // The monitor itself.
    modport slave (
        input  i_en,
        input  i_div_clk,
        output o_rise_pulse,
        output o_fall_pulse,
        output o_locked,
        output o_err,
        output o_lost,
        output o_last_half
    );
endinterface

// File: rtl/div_clk_monitor.sv
// Receive-side checker for the divided clock: synchronises it, measures every
// half period in i_clk cycles and reports lock, error and loss.
module div_clk_monitor #(
    parameter int unsigned HALF_PERIOD = 16,
    parameter int unsigned TOL         = 1,
    parameter int unsigned LOCK_CNT    = 4,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    div_clk_monitor_if.slave  mon_if
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned GOOD_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  TO_CNT   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W:0]    LO_LIM   = (HALF_PERIOD > TOL) ? (CNT_W+1)'(HALF_PERIOD - TOL) : '0;
    localparam logic [CNT_W:0]    HI_LIM   = (CNT_W+1)'(HALF_PERIOD + TOL);
    localparam logic [GOOD_W-1:0] GOOD_TOP = GOOD_W'(LOCK_CNT - 1);
    localparam logic [GOOD_W-1:0] GOOD_SAT = GOOD_W'(LOCK_CNT);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACQUIRE = 3'd1,
        TRACK   = 3'd2,
        LOCKED  = 3'd3,
        LOST    = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic               s1_q, s2_q, s3_q;
    logic [CNT_W-1:0]   half_cnt_q, half_cnt_d;
    logic [GOOD_W-1:0]  good_cnt_q, good_cnt_d;
    logic               err_evt_q, err_evt_d;
    logic [CNT_W-1:0]   last_half_q, last_half_d;
    logic               rise_q, fall_q;
    logic               locked_q, lost_q, err_q;

    logic               edge_c;
    logic               rise_c;
    logic               fall_c;
    logic [CNT_W-1:0]   meas_c;
    logic               good_c;
    logic               timeout_c;

    // Two-flop synchroniser plus history flop; keeps running while disabled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= mon_if.i_div_clk;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Edge detection and the measurement of the half period just closed.
    always_comb begin
        edge_c    = s2_q ^ s3_q;
        rise_c    = s2_q & ~s3_q;
        fall_c    = ~s2_q & s3_q;
        meas_c    = (half_cnt_q == CNT_MAX) ? CNT_MAX : half_cnt_q + CNT_W'(1);
        good_c    = ({1'b0, meas_c} >= LO_LIM) && ({1'b0, meas_c} <= HI_LIM);
        timeout_c = (half_cnt_q == TO_CNT) && !edge_c;
    end

    // State, counters and internal event registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            half_cnt_q  <= '0;
            good_cnt_q  <= '0;
            err_evt_q   <= 1'b0;
            last_half_q <= '0;
        end else begin
            state_q     <= state_d;
            half_cnt_q  <= half_cnt_d;
            good_cnt_q  <= good_cnt_d;
            err_evt_q   <= err_evt_d;
            last_half_q <= last_half_d;
        end
    end

    // Next-state logic: edges are classified by the measured half period;
    // an edge in the timeout cycle takes priority over the timeout.
    always_comb begin
        state_d     = state_q;
        good_cnt_d  = good_cnt_q;
        err_evt_d   = 1'b0;
        last_half_d = last_half_q;
        if (edge_c) begin
            half_cnt_d  = '0;
            last_half_d = meas_c;
        end else if (half_cnt_q == CNT_MAX) begin
            half_cnt_d = CNT_MAX;
        end else begin
            half_cnt_d = half_cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                state_d    = ACQUIRE;
                half_cnt_d = '0;
                good_cnt_d = '0;
            end
            ACQUIRE: begin
                if (edge_c) begin
                    state_d    = TRACK;
                    good_cnt_d = '0;
                end else if (timeout_c) begin
                    state_d = LOST;
                end
            end
            TRACK: begin
                if (edge_c) begin
                    if (good_c) begin
                        if (good_cnt_q >= GOOD_TOP) begin
                            state_d    = LOCKED;
                            good_cnt_d = GOOD_SAT;
                        end else begin
                            good_cnt_d = good_cnt_q + GOOD_W'(1);
                        end
                    end else begin
                        err_evt_d  = 1'b1;
                        good_cnt_d = '0;
                    end
                end else if (timeout_c) begin
                    state_d = LOST;
                end
            end
            LOCKED: begin
                if (edge_c) begin
                    if (!good_c) begin
                        state_d    = TRACK;
                        err_evt_d  = 1'b1;
                        good_cnt_d = '0;
                    end
                end else if (timeout_c) begin
                    state_d = LOST;
                end
            end
            LOST: begin
                if (edge_c) begin
                    state_d    = TRACK;
                    good_cnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!mon_if.i_en) begin
            state_d     = IDLE;
            half_cnt_d  = '0;
            good_cnt_d  = '0;
            err_evt_d   = 1'b0;
            last_half_d = '0;
        end
    end

    // Registered outputs; status follows the state register one cycle later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rise_q   <= rise_c;
            fall_q   <= fall_c;
            locked_q <= mon_if.i_en && (state_q == LOCKED);
            lost_q   <= mon_if.i_en && (state_q == LOST);
            err_q    <= mon_if.i_en && err_evt_q;
        end
    end

    assign mon_if.o_rise_pulse = rise_q;
    assign mon_if.o_fall_pulse = fall_q;
    assign mon_if.o_locked     = locked_q;
    assign mon_if.o_err        = err_q;
    assign mon_if.o_lost       = lost_q;
    assign mon_if.o_last_half  = last_half_q;

endmodule

// File: tb/tb_div_clk_monitor.sv
// Directed bench for div_clk_monitor: lock, error, tolerance, loss and control events.
module tb_div_clk_monitor;

    logic clk;
    logic rst_n;
    div_clk_monitor_if mon_if ();

    div_clk_monitor #(
        .HALF_PERIOD (16),
        .TOL         (1),
        .LOCK_CNT    (4),
        .TIMEOUT     (64)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .mon_if  (mon_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Event log gathered just after every rising clock edge.
    int cyc = 0;
    int npulse = 0;
    int nrise = 0;
    int nerr = 0;
    int nlock = 0;
    int nlost = 0;
    int lock_cyc = 0;
    int unlock_cyc = 0;
    int lost_cyc = 0;
    int lost_fall_cyc = 0;
    int pulse_cyc [512];
    int err_cyc [64];
    int lh_at_err [64];
    logic p_locked = 1'b0;
    logic p_lost = 1'b0;

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (mon_if.o_rise_pulse || mon_if.o_fall_pulse) begin
            npulse = npulse + 1;
            pulse_cyc[npulse[8:0]] = cyc;
        end
        if (mon_if.o_rise_pulse) nrise = nrise + 1;
        if (mon_if.o_err) begin
            err_cyc[nerr[5:0]]   = cyc;
            lh_at_err[nerr[5:0]] = int'(mon_if.o_last_half);
            nerr = nerr + 1;
        end
        if (mon_if.o_locked && !p_locked) begin
            nlock = nlock + 1;
            lock_cyc = cyc;
        end
        if (!mon_if.o_locked && p_locked) unlock_cyc = cyc;
        if (mon_if.o_lost && !p_lost) begin
            nlost = nlost + 1;
            lost_cyc = cyc;
        end
        if (!mon_if.o_lost && p_lost) lost_fall_cyc = cyc;
        p_locked = mon_if.o_locked;
        p_lost   = mon_if.o_lost;
    end

    function automatic int pc(input int k);
        return pulse_cyc[k[8:0]];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One half period of n i_clk cycles: toggle, then hold.
    task automatic half(input int n);
        @(negedge clk);
        mon_if.i_div_clk = ~mon_if.i_div_clk;
        repeat (n - 1) @(negedge clk);
    endtask

    int b, e, r, nl, tog;
    logic got;

    initial begin
        rst_n = 1'b0;
        mon_if.i_en = 1'b0;
        mon_if.i_div_clk = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_rise", 32'(mon_if.o_rise_pulse), 0);
        chk("rst_fall", 32'(mon_if.o_fall_pulse), 0);
        chk("rst_locked", 32'(mon_if.o_locked), 0);
        chk("rst_err", 32'(mon_if.o_err), 0);
        chk("rst_lost", 32'(mon_if.o_lost), 0);
        chk("rst_last_half", 32'(mon_if.o_last_half), 0);

        rst_n = 1'b1;
        @(negedge clk);
        mon_if.i_en = 1'b1;
        repeat (3) @(negedge clk);

        // 1: nominal /32 clock, lock one cycle after the 5th pulse
        b = npulse;
        @(negedge clk);
        tog = cyc;
        mon_if.i_div_clk = 1'b1;
        repeat (15) @(negedge clk);
        repeat (6) half(16);
        chk("s1_pulse_latency", 32'(pc(b + 1) - tog), 3);
        chk("s1_pulse_spacing", 32'(pc(b + 2) - pc(b + 1)), 16);
        chk("s1_rises", 32'(nrise), 4);
        chk("s1_lock_count", 32'(nlock), 1);
        chk("s1_lock_time", 32'(lock_cyc - pc(b + 5)), 1);
        chk("s1_locked", 32'(mon_if.o_locked), 1);
        chk("s1_last_half", 32'(mon_if.o_last_half), 16);
        chk("s1_no_err", 32'(nerr), 0);

        // 2: one short 12-cycle half while locked
        b = npulse; e = nerr; nl = nlock;
        half(12);
        repeat (5) half(16);
        chk("s2_err_count", 32'(nerr - e), 1);
        chk("s2_err_time", 32'(err_cyc[e[5:0]] - pc(b + 2)), 1);
        chk("s2_err_last_half", 32'(lh_at_err[e[5:0]]), 12);
        chk("s2_unlock_with_err", 32'(unlock_cyc), 32'(err_cyc[e[5:0]]));
        chk("s2_relock_time", 32'(lock_cyc - pc(b + 6)), 1);
        chk("s2_relock_count", 32'(nlock - nl), 1);

        // 3: tolerance boundary 15/17 good, 14/18 bad
        b = npulse; e = nerr; nl = nlock;
        half(15); half(17); half(16); half(14);
        half(16); half(16); half(18);
        repeat (5) half(16);
        chk("s3_err_count", 32'(nerr - e), 2);
        chk("s3_err14_time", 32'(err_cyc[e[5:0]] - pc(b + 5)), 1);
        chk("s3_err14_value", 32'(lh_at_err[e[5:0]]), 14);
        chk("s3_err18_time", 32'(err_cyc[(e + 1) & 63] - pc(b + 8)), 1);
        chk("s3_err18_value", 32'(lh_at_err[(e + 1) & 63]), 18);
        chk("s3_relock_count", 32'(nlock - nl), 1);
        chk("s3_relock_time", 32'(lock_cyc - pc(b + 12)), 1);

        // 4: divided clock stops, then resumes
        b = npulse; e = nerr; nl = nlock;
        got = 1'b0;
        for (int i = 0; i < 120 && !got; i++) begin
            @(negedge clk);
            if (mon_if.o_lost) got = 1'b1;
        end
        chk("s4_lost_seen", 32'(got), 1);
        chk("s4_lost_time", 32'(lost_cyc - pc(b)), 65);
        chk("s4_unlock_with_lost", 32'(unlock_cyc), 32'(lost_cyc));
        chk("s4_locked_low", 32'(mon_if.o_locked), 0);
        r = npulse;
        repeat (6) half(16);
        chk("s4_lost_clear_time", 32'(lost_fall_cyc - pc(r + 1)), 1);
        chk("s4_relock_time", 32'(lock_cyc - pc(r + 5)), 1);
        chk("s4_no_err", 32'(nerr - e), 0);
        chk("s4_lost_low", 32'(mon_if.o_lost), 0);

        // 5: edge lands exactly in the timeout cycle
        b = npulse; e = nerr; nl = nlost;
        half(64);
        repeat (5) half(16);
        chk("s5_no_lost", 32'(nlost - nl), 0);
        chk("s5_err_count", 32'(nerr - e), 1);
        chk("s5_err_time", 32'(err_cyc[e[5:0]] - pc(b + 2)), 1);
        chk("s5_err_value", 32'(lh_at_err[e[5:0]]), 64);
        chk("s5_relock_time", 32'(lock_cyc - pc(b + 6)), 1);

        // 6a: drop enable while locked
        chk("s6_locked_before", 32'(mon_if.o_locked), 1);
        mon_if.i_en = 1'b0;
        @(negedge clk);
        chk("s6_en_locked", 32'(mon_if.o_locked), 0);
        chk("s6_en_lost", 32'(mon_if.o_lost), 0);
        chk("s6_en_err", 32'(mon_if.o_err), 0);
        chk("s6_en_last_half", 32'(mon_if.o_last_half), 0);
        mon_if.i_en = 1'b1;
        repeat (3) @(negedge clk);
        repeat (6) half(16);
        chk("s6_relocked", 32'(mon_if.o_locked), 1);

        // 6b: asynchronous reset in the middle of a half
        @(negedge clk);
        mon_if.i_div_clk = ~mon_if.i_div_clk;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_rst_locked", 32'(mon_if.o_locked), 0);
        chk("s6_rst_last_half", 32'(mon_if.o_last_half), 0);
        chk("s6_rst_pulses", 32'(mon_if.o_rise_pulse | mon_if.o_fall_pulse), 0);
        mon_if.i_div_clk = 1'b0;
        repeat (3) @(negedge clk);
        b = npulse;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("s6_no_pulse_on_release", 32'(npulse - b), 0);
        chk("s6_locked_after_release", 32'(mon_if.o_locked), 0);
        nl = nlock;
        repeat (7) half(16);
        chk("s6_relock_count", 32'(nlock - nl), 1);
        chk("s6_relock_time", 32'(lock_cyc - pc(b + 5)), 1);
        chk("s6_relock_last_half", 32'(mon_if.o_last_half), 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
